benes_pipe_net: RTL and testbench

Parametrised, fully pipelined Benes permutation network for the FHE interconnect. It routes SIZE lanes of DATA_WIDTH bits through STAGE_NUM columns of 2x2 switches, with a register after every stage. It uses a valid/ready handshake with whole-pipe stall and a double-buffered switch-control word, so reconfiguration never corrupts data already in flight. It sits between the FHE ALU lane outputs and the lane-permutation consumers.

---
 rtl/benes_pipe_net_pkg.sv | 47 ++++
 rtl/benes_stage.sv | 40 ++++
 rtl/benes_pipe_net.sv | 109 ++++++++++
 tb/tb_benes_pipe_net.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/benes_pipe_net_pkg.sv
// rtl/benes_pipe_net_pkg.sv - shared sizes, lane type and Benes inter-stage routing helpers
package benes_pipe_net_pkg;
   localparam int SIZE       = 8;
   localparam int DATA_WIDTH = 8;
   localparam int LAYER_NUM  = $clog2(SIZE);
   localparam int STAGE_NUM  = 2*LAYER_NUM-1;
   localparam int SWITCH_NUM = SIZE/2;
   localparam int MID_STAGE  = STAGE_NUM/2;
   localparam int CTRL_W     = STAGE_NUM*SWITCH_NUM;

   typedef logic [DATA_WIDTH-1:0] lane_t;

   function automatic int abs_int(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int pow2(input int e);
      return 1 << e;
   endfunction

   function automatic int log2_int(input int v);
      int r;
      r = 0;
      while (pow2(r) < v) r++;
      return r;
   endfunction

   // Input port of stage+1 fed by output port p_out of stage, for any power-of-two size.
   function automatic int link(input int size, input int stage, input int p_out);
      int mid;
      int layer;
      int rows;
      int sub;
      int res;
      mid   = (2*log2_int(size)-1)/2;
      layer = mid - abs_int(stage-mid);
      rows  = size >> layer;
      sub   = p_out / rows;
      if (stage < mid)
         res = (p_out%rows)/2 + (rows/2)*(2*sub + p_out%2);
      else if (sub%2 == 0)
         res = (p_out%rows)*2 + sub*rows;
      else
         res = (p_out%rows)*2 + (sub-1)*rows + 1;
      return res;
   endfunction
endpackage

// File: rtl/benes_stage.sv
// rtl/benes_stage.sv - one column of 2x2 switches followed by its hold-enabled pipeline register
module benes_stage
   import benes_pipe_net_pkg::*;
#(
   parameter int SIZE       = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       hold,
   input  logic                       in_valid,
   input  logic [SIZE*DATA_WIDTH-1:0] in_data,
   input  logic [SIZE/2-1:0]          ctrl,
   output logic                       out_valid,
   output logic [SIZE*DATA_WIDTH-1:0] out_data
);
   localparam int SW = SIZE/2;

   logic [SIZE*DATA_WIDTH-1:0] sw_data;

   always_comb begin
      sw_data = in_data;
      for (int j = 0; j < SW; j++) begin
         if (ctrl[j]) begin
            sw_data[2*j*DATA_WIDTH +: DATA_WIDTH]     = in_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
            sw_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH] = in_data[2*j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!hold) begin
         out_valid <= in_valid;
         out_data  <= sw_data;
      end
   end
endmodule

// File: rtl/benes_pipe_net.sv
// rtl/benes_pipe_net.sv - pipelined Benes permutation network with whole-pipe stall and per-beat control
module benes_pipe_net
   import benes_pipe_net_pkg::*;
#(
   parameter  int SIZE       = benes_pipe_net_pkg::SIZE,
   parameter  int DATA_WIDTH = benes_pipe_net_pkg::DATA_WIDTH,
   localparam int LAYER_NUM  = $clog2(SIZE),
   localparam int STAGE_NUM  = 2*LAYER_NUM-1,
   localparam int SWITCH_NUM = SIZE/2,
   localparam int CTRL_W     = STAGE_NUM*SWITCH_NUM,
   localparam int OCC_W      = $clog2(STAGE_NUM+1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SIZE*DATA_WIDTH-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SIZE*DATA_WIDTH-1:0] out_data,
   input  logic                       cfg_wr,
   input  logic [CTRL_W-1:0]          cfg_word,
   output logic [CTRL_W-1:0]          cfg_q,
   output logic [OCC_W-1:0]           occupancy
);
   // Control bits still owed to downstream stages, packed stage after stage, lowest stage first.
   localparam int REST_TOT = SWITCH_NUM*STAGE_NUM*(STAGE_NUM-1)/2;

   logic [SIZE*DATA_WIDTH-1:0] st_in    [STAGE_NUM];
   logic [SIZE*DATA_WIDTH-1:0] st_out   [STAGE_NUM];
   logic                       st_vin   [STAGE_NUM];
   logic                       st_vout  [STAGE_NUM];
   logic [SWITCH_NUM-1:0]      st_ctrl  [STAGE_NUM];
   logic [REST_TOT-1:0]        rest_d;
   logic [REST_TOT-1:0]        rest_q;
   logic                       stall;
   logic                       accept;
   logic                       emit;

   assign out_valid = st_vout[STAGE_NUM-1];
   assign out_data  = st_out[STAGE_NUM-1];
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;

   assign st_vin[0] = in_valid;
   assign st_in[0]  = in_data;

   genvar s, p;
   generate
      for (s = 0; s < STAGE_NUM; s++) begin : g_stage
         localparam int REST_W = (STAGE_NUM-1-s)*SWITCH_NUM;
         localparam int OFF    = SWITCH_NUM*(s*(STAGE_NUM-1) - (s*(s-1))/2);
         localparam int PREV   = SWITCH_NUM*((s-1)*(STAGE_NUM-1) - ((s-1)*(s-2))/2);

         if (s == 0) begin : g_first
            assign st_ctrl[0]             = cfg_q[SWITCH_NUM-1:0];
            assign rest_d[0 +: REST_W]    = cfg_q[CTRL_W-1:SWITCH_NUM];
         end else begin : g_next
            assign st_ctrl[s] = rest_q[PREV +: SWITCH_NUM];
            if (REST_W > 0) begin : g_rest
               assign rest_d[OFF +: REST_W] = rest_q[PREV+SWITCH_NUM +: REST_W];
            end
            assign st_vin[s] = st_vout[s-1];
            for (p = 0; p < SIZE; p++) begin : g_link
               localparam int L = link(SIZE, s-1, p);
               assign st_in[s][L*DATA_WIDTH +: DATA_WIDTH] = st_out[s-1][p*DATA_WIDTH +: DATA_WIDTH];
            end
         end

         benes_stage #(
            .SIZE       (SIZE),
            .DATA_WIDTH (DATA_WIDTH)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .hold      (stall),
            .in_valid  (st_vin[s]),
            .in_data   (st_in[s]),
            .ctrl      (st_ctrl[s]),
            .out_valid (st_vout[s]),
            .out_data  (st_out[s])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!stall) rest_q <= rest_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q <= '0;
      end else if (cfg_wr) begin
         cfg_q <= cfg_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occupancy <= '0;
      end else if (accept && !emit) begin
         occupancy <= occupancy + OCC_W'(1);
      end else if (emit && !accept) begin
         occupancy <= occupancy - OCC_W'(1);
      end
   end
endmodule

// File: tb/tb_benes_pipe_net.sv
// tb/tb_benes_pipe_net.sv - directed vector and corner-sequence bench for benes_pipe_net (SIZE=8)
module tb_benes_pipe_net;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        cfg_wr;
   logic [19:0] cfg_word;
   logic [19:0] cfg_q;
   logic [2:0]  occupancy;

   int errors;
   int checks;

   typedef struct {
      logic [19:0] cfg;
      logic [63:0] din;
      logic [63:0] dout;
   } vec_t;

   vec_t vecs [8];

   benes_pipe_net dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cfg_wr    (cfg_wr),
      .cfg_word  (cfg_word),
      .cfg_q     (cfg_q),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input int b);
      logic [63:0] d;
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(b*16 + i);
      return d;
   endfunction

   function automatic logic [63:0] swap_pairs(input logic [63:0] d);
      logic [63:0] r;
      for (int i = 0; i < 8; i += 2) begin
         r[i*8 +: 8]     = d[(i+1)*8 +: 8];
         r[(i+1)*8 +: 8] = d[i*8 +: 8];
      end
      return r;
   endfunction

   task automatic load_cfg(input logic [19:0] w);
      cfg_word = w;
      cfg_wr   = 1'b1;
      step();
      cfg_wr   = 1'b0;
      check("cfg_q load", 64'(cfg_q), 64'(w));
   endtask

   task automatic one_beat(input string name, input logic [63:0] din, input logic [63:0] dexp);
      int lat;
      check({name, " in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data  = din;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check({name, " latency"}, 64'(lat), 64'd5);
      check({name, " data"}, out_data, dexp);
      step();
      check({name, " occupancy"}, 64'(occupancy), 64'd0);
   endtask

   initial begin
      int rx;
      int ghost;
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      cfg_wr    = 1'b0;
      cfg_word  = '0;

      vecs[0] = '{20'h00000, 64'h17161514_13121110, 64'h17161514_13121110};
      vecs[1] = '{20'hF0000, 64'h17161514_13121110, 64'h16171415_12131011};
      vecs[2] = '{20'h00001, 64'h17161514_13121110, 64'h17161514_13121011};
      vecs[3] = '{20'h00100, 64'h17161514_13121110, 64'h17161510_13121114};
      vecs[4] = '{20'h00010, 64'h17161514_13121110, 64'h17161514_13101112};
      vecs[5] = '{20'h08000, 64'h17161514_13121110, 64'h15161714_13121110};
      vecs[6] = '{20'h00000, 64'hF0E1D2C3_B4A59687, 64'hF0E1D2C3_B4A59687};
      vecs[7] = '{20'hF0000, 64'hF0E1D2C3_B4A59687, 64'hE1F0C3D2_A5B48796};

      step();
      step();
      rst = 1'b0;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_data", out_data, 64'd0);
      check("reset occupancy", 64'(occupancy), 64'd0);
      check("reset cfg_q", 64'(cfg_q), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);

      for (int v = 0; v < 8; v++) begin
         load_cfg(vecs[v].cfg);
         one_beat($sformatf("vec%0d", v), vecs[v].din, vecs[v].dout);
      end

      // Reconfigure on beat 4's accept cycle: beats 0-4 keep the old routing.
      load_cfg(20'h00000);
      rx = 0;
      for (int t = 0; t < 30; t++) begin
         in_valid = (t < 8);
         in_data  = mk(t);
         cfg_wr   = (t == 4);
         cfg_word = 20'hF0000;
         step();
         if (out_valid) begin
            if (rx < 8)
               check($sformatf("stream beat%0d", rx), out_data, (rx < 5) ? mk(rx) : swap_pairs(mk(rx)));
            rx++;
         end
      end
      in_valid = 1'b0;
      cfg_wr   = 1'b0;
      check("stream beat count", 64'(rx), 64'd8);
      check("stream cfg_q", 64'(cfg_q), 64'hF0000);
      check("stream occupancy", 64'(occupancy), 64'd0);

      load_cfg(20'h00000);
      out_ready = 1'b0;
      for (int b = 0; b < 5; b++) begin
         in_valid = 1'b1;
         in_data  = mk(8 + b);
         step();
      end
      in_data = mk(13);
      check("full out_valid", 64'(out_valid), 64'd1);
      check("full in_ready", 64'(in_ready), 64'd0);
      check("full occupancy", 64'(occupancy), 64'd5);
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("stall%0d data", k), out_data, mk(8));
         check($sformatf("stall%0d in_ready", k), 64'(in_ready), 64'd0);
         check($sformatf("stall%0d occupancy", k), 64'(occupancy), 64'd5);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("drain%0d valid", k), 64'(out_valid), 64'd1);
         check($sformatf("drain%0d data", k), out_data, mk(8 + k));
         step();
      end
      check("drain empty", 64'(out_valid), 64'd0);
      check("drain occupancy", 64'(occupancy), 64'd0);

      load_cfg(20'h00001);
      for (int b = 0; b < 3; b++) begin
         in_valid = 1'b1;
         in_data  = mk(b);
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midreset out_valid", 64'(out_valid), 64'd0);
      check("midreset occupancy", 64'(occupancy), 64'd0);
      check("midreset cfg_q", 64'(cfg_q), 64'd0);
      ghost = 0;
      for (int k = 0; k < 6; k++) begin
         if (out_valid) ghost++;
         step();
      end
      check("midreset ghost beats", 64'(ghost), 64'd0);
      one_beat("post reset", 64'h17161514_13121110, 64'h17161514_13121110);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
